// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: default widths, the buffered entry
// layout and the drain controller states.
package store_buffer_pkg;

   localparam int SB_ADDR_W = 10;
   localparam int SB_DATA_W = 16;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2
   } sb_state_e;

endpackage

// File: rtl/sb_forward_match.sv
// DEPTH-way address compare over the buffered stores with youngest-hit
// select; the youngest entry is the one just behind the tail pointer.
module sb_forward_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0]     entries,
   input  logic      [DEPTH-1:0]     valid,
   input  logic      [PTR_W-1:0]     tail,
   input  logic      [SB_ADDR_W-1:0] addr,
   output logic                      hit,
   output logic      [SB_DATA_W-1:0] data
);

   logic [DEPTH-1:0] match;

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_cmp
         assign match[i] = valid[i] & (entries[i].addr == addr);
      end
   endgenerate

   // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last hit wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         idx = tail - PTR_W'(k);
         if (match[idx]) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the datapath MEM stage and data memory: queues stores,
// forwards loads from the youngest buffered match, and drains one store per
// cycle whenever a load miss is not using the memory port.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] Cpu_Address,
   input  logic [DATA_W-1:0] Cpu_Write_Data,
   input  logic              Cpu_MemRead,
   input  logic              Cpu_MemWrite,
   output logic [DATA_W-1:0] Cpu_Read_Data,
   output logic              Stall,
   input  logic              Flush,
   output logic              Empty,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic [DATA_W-1:0] Mem_Write_Data,
   output logic              Mem_MemRead,
   output logic              Mem_MemWrite,
   input  logic [DATA_W-1:0] Mem_Read_Data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]      head, tail;
   logic [PTR_W:0]        count, count_nxt;
   sb_entry_t [DEPTH-1:0] entries;
   logic [DEPTH-1:0]      valid;
   sb_state_e             state, state_nxt;

   logic              full, empty, push, pop;
   logic              load, load_hit, load_miss;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign Empty = empty;

   // A draining flush refuses new stores so the buffer is guaranteed to empty.
   assign Stall = Cpu_MemWrite & (full | (state == ST_FLUSH));
   assign push  = Cpu_MemWrite & ~Stall;

   // Loads are suppressed while in reset so the memory port stays quiet.
   assign load      = Cpu_MemRead & ~Cpu_MemWrite & ~Rst;
   assign load_hit  = load & fwd_hit;
   assign load_miss = load & ~fwd_hit;
   assign pop       = ~empty & ~load_miss;

   assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

   always_comb begin
      logic [PTR_W-1:0] off;
      off   = '0;
      valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off      = PTR_W'(i) - head;
         valid[i] = ({1'b0, off} < count);
      end
   end

   sb_forward_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fwd (
      .entries (entries),
      .valid   (valid),
      .tail    (tail),
      .addr    (Cpu_Address),
      .hit     (fwd_hit),
      .data    (fwd_data)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= ST_IDLE;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         count <= count_nxt;
         state <= state_nxt;
      end
   end

   // Payload needs no reset; validity comes from the pointers and count.
   always_ff @(posedge Clk) begin
      if (push) begin
         entries[tail].addr <= Cpu_Address;
         entries[tail].data <= Cpu_Write_Data;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (Flush)     state_nxt = ST_FLUSH;
            else if (push) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (Flush)                state_nxt = ST_FLUSH;
            else if (count_nxt == '0) state_nxt = ST_IDLE;
         end
         ST_FLUSH: begin
            if (empty) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign Mem_MemRead    = load_miss;
   assign Mem_MemWrite   = pop;
   assign Mem_Address    = load_miss ? Cpu_Address : entries[head].addr;
   assign Mem_Write_Data = entries[head].data;

   always_comb begin
      Cpu_Read_Data = '0;
      if (load_hit)       Cpu_Read_Data = fwd_data;
      else if (load_miss) Cpu_Read_Data = Mem_Read_Data;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based
// reference model and an independent shadow copy of data memory.
module tb_store_buffer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;

   logic              Clk = 1'b0;
   logic              Rst;
   logic [ADDR_W-1:0] Cpu_Address;
   logic [DATA_W-1:0] Cpu_Write_Data;
   logic              Cpu_MemRead, Cpu_MemWrite, Flush;
   logic [DATA_W-1:0] Cpu_Read_Data;
   logic              Stall, Empty;
   logic [ADDR_W-1:0] Mem_Address;
   logic [DATA_W-1:0] Mem_Write_Data, Mem_Read_Data;
   logic              Mem_MemRead, Mem_MemWrite;

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .Cpu_Address    (Cpu_Address),
      .Cpu_Write_Data (Cpu_Write_Data),
      .Cpu_MemRead    (Cpu_MemRead),
      .Cpu_MemWrite   (Cpu_MemWrite),
      .Cpu_Read_Data  (Cpu_Read_Data),
      .Stall          (Stall),
      .Flush          (Flush),
      .Empty          (Empty),
      .Mem_Address    (Mem_Address),
      .Mem_Write_Data (Mem_Write_Data),
      .Mem_MemRead    (Mem_MemRead),
      .Mem_MemWrite   (Mem_MemWrite),
      .Mem_Read_Data  (Mem_Read_Data)
   );

   always #5 Clk = ~Clk;

   // Data memory attached to the DUT, and the model's own view of it.
   logic [DATA_W-1:0] mem     [0:1023];
   logic [DATA_W-1:0] ref_mem [0:1023];
   assign Mem_Read_Data = mem[Mem_Address];
   always @(posedge Clk) if (Mem_MemWrite) mem[Mem_Address] <= Mem_Write_Data;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } st_t;

   st_t q[$];
   bit  fl;
   bit  m_push, m_pop;
   int  m_n;
   int  checks   = 0;
   int  failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drv(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input bit fls);
      Cpu_MemRead    = rd;
      Cpu_MemWrite   = wr;
      Cpu_Address    = a;
      Cpu_Write_Data = d;
      Flush          = fls;
   endtask

   // Called at posedge+1; checks every output at the following negedge.
   task automatic settle();
      bit                load, hit, miss, stall;
      logic [DATA_W-1:0] hd, exp_rd;
      #4;
      m_n   = q.size();
      stall = Cpu_MemWrite && (m_n == DEPTH || fl);
      load  = Cpu_MemRead && !Cpu_MemWrite;
      hit   = 1'b0;
      hd    = '0;
      foreach (q[i]) if (q[i].a == Cpu_Address) begin hit = 1'b1; hd = q[i].d; end
      miss   = load && !hit;
      exp_rd = !load ? '0 : (hit ? hd : ref_mem[Cpu_Address]);
      m_pop  = (m_n > 0) && !miss;
      m_push = Cpu_MemWrite && !stall;
      chk("stall", Stall, stall);
      chk("empty", Empty, m_n == 0);
      chk("mem_wr", Mem_MemWrite, m_pop);
      chk("mem_rd", Mem_MemRead, miss);
      chk("rdata", Cpu_Read_Data, exp_rd);
      if (m_pop) begin
         chk("drain_addr", Mem_Address, q[0].a);
         chk("drain_data", Mem_Write_Data, q[0].d);
      end
      if (miss) chk("miss_addr", Mem_Address, Cpu_Address);
   endtask

   task automatic advance();
      @(posedge Clk);
      if (m_pop) begin
         ref_mem[q[0].a] = q[0].d;
         void'(q.pop_front());
      end
      if (m_push) q.push_back(st_t'{Cpu_Address, Cpu_Write_Data});
      if (fl) fl = (m_n != 0);
      else    fl = Flush;
      #1;
   endtask

   task automatic op(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input bit fls);
      drv(rd, wr, a, d, fls);
      settle();
      advance();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     <= (i == 32) ? 16'h0F0F : 16'(i * 37 + 5);
         ref_mem[i]  = (i == 32) ? 16'h0F0F : 16'(i * 37 + 5);
      end
      fl = 1'b0;

      // Reset state, with requests present to show they are masked.
      Rst = 1'b1;
      drv(1, 0, 10'h020, 16'h0, 0);
      #1;
      chk("rst_empty", Empty, 1);
      chk("rst_mem_wr", Mem_MemWrite, 0);
      chk("rst_mem_rd", Mem_MemRead, 0);
      chk("rst_rdata", Cpu_Read_Data, 0);
      drv(0, 1, 10'h001, 16'h1, 0);
      #1;
      chk("rst_stall", Stall, 0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;

      // Single store then drain.
      drv(0, 1, 10'h005, 16'h1234, 0);
      settle();
      chk("t1_stall", Stall, 0);
      advance();
      drv(0, 0, 10'h000, 16'h0, 0);
      settle();
      chk("t1_mwr", Mem_MemWrite, 1);
      chk("t1_maddr", Mem_Address, 10'h005);
      chk("t1_mdata", Mem_Write_Data, 16'h1234);
      advance();
      drv(0, 0, 10'h000, 16'h0, 0);
      settle();
      chk("t1_empty", Empty, 1);
      advance();

      // Same-address stores back to back; load picks the newer data.
      op(0, 1, 10'h010, 16'hAAAA, 0);
      op(0, 1, 10'h010, 16'hBBBB, 0);
      drv(1, 0, 10'h010, 16'h0, 0);
      settle();
      chk("t2_fwd", Cpu_Read_Data, 16'hBBBB);
      chk("t2_mrd", Mem_MemRead, 0);
      advance();
      op(0, 0, 10'h0, 16'h0, 0);

      // Load miss blocks the pending drain for one cycle.
      op(0, 1, 10'h030, 16'h3333, 0);
      drv(1, 0, 10'h020, 16'h0, 0);
      settle();
      chk("t4_rdata", Cpu_Read_Data, 16'h0F0F);
      chk("t4_mwr", Mem_MemWrite, 0);
      advance();
      drv(0, 0, 10'h0, 16'h0, 0);
      settle();
      chk("t4_resume", Mem_MemWrite, 1);
      advance();

      // Flush with a pending store: stores stall until drained and FSM idles.
      op(0, 1, 10'h040, 16'h4444, 0);
      op(1, 0, 10'h3FF, 16'h0, 1);
      drv(0, 1, 10'h041, 16'h4545, 0);
      settle();
      chk("t5_stall", Stall, 1);
      chk("t5_mwr", Mem_MemWrite, 1);
      advance();
      drv(0, 1, 10'h041, 16'h4545, 0);
      settle();
      chk("t5_empty", Empty, 1);
      chk("t5_stall2", Stall, 1);
      advance();
      drv(0, 1, 10'h042, 16'h4646, 0);
      settle();
      chk("t5_idle", Stall, 0);
      advance();
      op(0, 0, 10'h0, 16'h0, 0);

      // Flush on an empty buffer.
      op(0, 0, 10'h0, 16'h0, 1);
      op(0, 1, 10'h050, 16'h5050, 0);
      op(0, 1, 10'h051, 16'h5151, 0);
      op(0, 0, 10'h0, 16'h0, 0);

      // Asynchronous reset in the middle of a drain.
      op(0, 1, 10'h0AA, 16'h5555, 0);
      drv(0, 0, 10'h0, 16'h0, 0);
      #1;
      chk("t6_pre", Mem_MemWrite, 1);
      Rst = 1'b1;
      #1;
      chk("t6_mwr", Mem_MemWrite, 0);
      chk("t6_empty", Empty, 1);
      @(posedge Clk);
      q.delete();
      fl = 1'b0;
      #1;
      Rst = 1'b0;
      for (int i = 0; i < 3; i++) op(0, 0, 10'h0, 16'h0, 0);
      op(1, 0, 10'h0AA, 16'h0, 0);

      // Randomized traffic over a small address set to provoke hits.
      for (int n = 0; n < 800; n++) begin
         int                r;
         logic [ADDR_W-1:0] a;
         r = $urandom_range(0, 9);
         a = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
         op(r >= 3 && r < 8, r < 4, a, DATA_W'($urandom), $urandom_range(0, 15) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
